// File: rtl/mips_pkg.sv
// Shared register-file constants and the write-queue entry type.
package mips_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Write-back queue storage: circular buffer with up to two pushes and one pop
// per cycle. Port A is always the older of a same-cycle pair.
// WB_BYPASS_EN: exports per-slot data for the bypass lookup in reg_writeback.
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_a,
  input  wb_entry_t                    entry_a,
  input  logic                         push_b,
  input  wb_entry_t                    entry_b,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic [DEPTH-1:0][REG_W-1:0]  entry_rd,
`ifdef WB_BYPASS_EN
  output logic [DEPTH-1:0][DATA_W-1:0] entry_data,
`endif
  output logic [PW-1:0]                rd_ptr,
  output logic [CW-1:0]                count
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0] wr_ptr;
  logic          pop_ok;

  assign pop_ok = pop && (count != '0);
  assign head   = mem[rd_ptr];

  // Expose per-slot fields for the hazard/bypass match logic.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_rd[i] = mem[i].rd;
`ifdef WB_BYPASS_EN
      entry_data[i] = mem[i].data;
`endif
    end
  end

  // Entry storage; slot B lands one past slot A when both push together.
  always_ff @(posedge clk) begin
    if (push_a) mem[wr_ptr] <= entry_a;
    if (push_b) mem[wr_ptr + PW'(push_a)] <= entry_b;
  end

  // Pointers wrap naturally at DEPTH (power of two); count spans 0..DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_a) + PW'(push_b);
      if (pop_ok) rd_ptr <= rd_ptr + PW'(1);
      count  <= count + CW'(push_a) + CW'(push_b) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// Register write-back stage: merges ALU and load results into an in-order
// queue, drains one write per cycle and reports source-register hazards.
// Handshake: a request is taken on a rising edge when its valid=1, wb_ready=1
// and rd!=0; wb_ready depends only on queue occupancy, never on the requests.
// WB_BYPASS_EN: enables fwd_* data from the youngest pending write.
module reg_writeback
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wb_ready,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] writedata,
  output logic              regwrite,
  input  logic [REG_W-1:0]  rs,
  input  logic [REG_W-1:0]  rt,
  output logic              rs_pending,
  output logic              rt_pending,
  output logic              fwd_rs_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rt_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic                        mem_acc, alu_acc, pop;
  wb_entry_t                   head;
  logic [DEPTH-1:0][REG_W-1:0] entry_rd;
  logic [PW-1:0]               rd_ptr;
  logic [CW-1:0]               count;
  logic                        rs_match, rt_match;
`ifdef WB_BYPASS_EN
  logic [DEPTH-1:0][DATA_W-1:0] entry_data;
`endif

  assign wb_ready = (CW'(DEPTH) - count) >= CW'(2);
  assign mem_acc  = mem_valid && wb_ready && (mem_rd != ZERO_REG);
  assign alu_acc  = alu_valid && wb_ready && (alu_rd != ZERO_REG);
  assign pop      = (count != '0);

  // Load result is the older instruction, so it takes port A.
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_a     (mem_acc),
    .entry_a    ('{rd: mem_rd, data: mem_data}),
    .push_b     (alu_acc),
    .entry_b    ('{rd: alu_rd, data: alu_data}),
    .pop        (pop),
    .head       (head),
    .entry_rd   (entry_rd),
`ifdef WB_BYPASS_EN
    .entry_data (entry_data),
`endif
    .rd_ptr     (rd_ptr),
    .count      (count)
  );

  // Registered register-file write port; rd/writedata hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      regwrite  <= 1'b0;
      rd        <= '0;
      writedata <= '0;
    end else if (pop) begin
      regwrite  <= 1'b1;
      rd        <= head.rd;
      writedata <= head.data;
    end else begin
      regwrite  <= 1'b0;
    end
  end

  // Hazard match against the output stage and every occupied queue slot.
  always_comb begin
    rs_match = regwrite && (rd == rs);
    rt_match = regwrite && (rd == rt);
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (entry_rd[rd_ptr + PW'(k)] == rs) rs_match = 1'b1;
        if (entry_rd[rd_ptr + PW'(k)] == rt) rt_match = 1'b1;
      end
    end
  end

  assign rs_pending = rs_match && (rs != ZERO_REG);
  assign rt_pending = rt_match && (rt != ZERO_REG);

`ifdef WB_BYPASS_EN
  logic [DATA_W-1:0] rs_val, rt_val;

  // Scan oldest to youngest so the last hit (the youngest write) wins.
  always_comb begin
    rs_val = (regwrite && rd == rs) ? writedata : '0;
    rt_val = (regwrite && rd == rt) ? writedata : '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count) begin
        if (entry_rd[rd_ptr + PW'(k)] == rs) rs_val = entry_data[rd_ptr + PW'(k)];
        if (entry_rd[rd_ptr + PW'(k)] == rt) rt_val = entry_data[rd_ptr + PW'(k)];
      end
    end
  end

  assign fwd_rs_hit  = rs_pending;
  assign fwd_rt_hit  = rt_pending;
  assign fwd_rs_data = rs_pending ? rs_val : '0;
  assign fwd_rt_data = rt_pending ? rt_val : '0;
`else
  assign fwd_rs_hit  = 1'b0;
  assign fwd_rt_hit  = 1'b0;
  assign fwd_rs_data = '0;
  assign fwd_rt_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback (DEPTH=4). Inputs change on the falling
// edge; outputs are checked 1 time unit later, before the next rising edge.
module tb_reg_writeback;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid;
  logic [4:0]  alu_rd, mem_rd, rs, rt;
  logic [31:0] alu_data, mem_data;
  logic        wb_ready, regwrite, rs_pending, rt_pending, fwd_rs_hit, fwd_rt_hit;
  logic [4:0]  rd;
  logic [31:0] writedata, fwd_rs_data, fwd_rt_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];

  reg_writeback #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_ready(wb_ready), .rd(rd), .writedata(writedata), .regwrite(regwrite),
    .rs(rs), .rt(rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
    .fwd_rs_hit(fwd_rs_hit), .fwd_rs_data(fwd_rs_data),
    .fwd_rt_hit(fwd_rt_hit), .fwd_rt_data(fwd_rt_data)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct packed {
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        mv;  logic [4:0] mrd; logic [31:0] md;
    logic [4:0]  rs;  logic [4:0] rt;
    logic        e_rw; logic [4:0] e_rd; logic [31:0] e_wd; logic e_rdy;
    logic        e_rsp; logic e_rtp; logic [31:0] e_frs; logic [31:0] e_frt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
  endtask

  initial begin
    int sent, writes, cnt, acc, budget;
    logic [36:0] e;

    //            av ard ad        mv mrd md         rs rt | rw rd wd       rdy rsp rtp frs      frt
    vecs[0]  = '{1, 3, 32'd100,   0, 0, 0,          3, 0,   0, 0, 0,        1,  0,  0,  0,       0};
    vecs[1]  = '{0, 0, 0,         0, 0, 0,          3, 3,   0, 0, 0,        1,  1,  1,  100,     100};
    vecs[2]  = '{0, 0, 0,         0, 0, 0,          3, 0,   1, 3, 100,      1,  1,  0,  100,     0};
    vecs[3]  = '{1, 0, 32'd100,   0, 0, 0,          0, 3,   0, 3, 100,      1,  0,  0,  0,       0};
    vecs[4]  = '{0, 0, 0,         0, 0, 0,          0, 0,   0, 3, 100,      1,  0,  0,  0,       0};
    vecs[5]  = '{1, 6, 32'h5555,  1, 6, 32'hAAAA,   6, 7,   0, 3, 100,      1,  0,  0,  0,       0};
    vecs[6]  = '{0, 0, 0,         0, 0, 0,          6, 7,   0, 3, 100,      1,  1,  0,  'h5555,  0};
    vecs[7]  = '{0, 0, 0,         0, 0, 0,          6, 6,   1, 6, 'hAAAA,   1,  1,  1,  'h5555,  'h5555};
    vecs[8]  = '{0, 0, 0,         0, 0, 0,          6, 0,   1, 6, 'h5555,   1,  1,  0,  'h5555,  0};
    vecs[9]  = '{1, 4, 32'h44,    0, 0, 0,          4, 5,   0, 6, 'h5555,   1,  0,  0,  0,       0};
    vecs[10] = '{0, 0, 0,         0, 0, 0,          4, 5,   0, 6, 'h5555,   1,  1,  0,  'h44,    0};
    vecs[11] = '{0, 0, 0,         0, 0, 0,          4, 5,   1, 4, 'h44,     1,  1,  0,  'h44,    0};
    vecs[12] = '{0, 0, 0,         0, 0, 0,          4, 5,   0, 4, 'h44,     1,  0,  0,  0,       0};

    // Reset
    rst = 1'b1; rs = 0; rt = 0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    check("reset regwrite", 32'(regwrite), 0);
    check("reset rd", 32'(rd), 0);
    check("reset writedata", writedata, 0);
    check("reset wb_ready", 32'(wb_ready), 1);

    // Table vectors: single write, zero-reg drop, dual issue, hazard
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].mv, vecs[i].mrd, vecs[i].md);
      rs = vecs[i].rs; rt = vecs[i].rt;
      #1;
      check($sformatf("v%0d regwrite", i), 32'(regwrite), 32'(vecs[i].e_rw));
      check($sformatf("v%0d rd", i), 32'(rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d writedata", i), writedata, vecs[i].e_wd);
      check($sformatf("v%0d wb_ready", i), 32'(wb_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d rs_pending", i), 32'(rs_pending), 32'(vecs[i].e_rsp));
      check($sformatf("v%0d rt_pending", i), 32'(rt_pending), 32'(vecs[i].e_rtp));
      check($sformatf("v%0d fwd_rs_hit", i), 32'(fwd_rs_hit), 32'(BYP & vecs[i].e_rsp));
      check($sformatf("v%0d fwd_rt_hit", i), 32'(fwd_rt_hit), 32'(BYP & vecs[i].e_rtp));
      check($sformatf("v%0d fwd_rs_data", i), fwd_rs_data, BYP ? vecs[i].e_frs : 32'd0);
      check($sformatf("v%0d fwd_rt_data", i), fwd_rt_data, BYP ? vecs[i].e_frt : 32'd0);
    end

    // Fill: both sources every cycle the queue allows, eight writes in order
    sent = 0; writes = 0; cnt = 0; budget = 0;
    rs = 0; rt = 0;
    while ((sent < 8 || exp_q.size() > 0 || regwrite) && budget < 40) begin
      @(negedge clk); #1;
      budget++;
      check("fill wb_ready", 32'(wb_ready), 32'((4 - cnt) >= 2));
      if (regwrite) begin
        writes++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL fill extra write: got rd=%0d expected no write", rd);
        end else begin
          e = exp_q.pop_front();
          check("fill rd", 32'(rd), 32'(e[36:32]));
          check("fill writedata", writedata, e[31:0]);
        end
      end
      if (sent < 8 && wb_ready) begin
        drive(1, 5'(9 + sent), 32'h1001 + 32'(sent), 1, 5'(8 + sent), 32'h1000 + 32'(sent));
        exp_q.push_back({5'(8 + sent), 32'h1000 + 32'(sent)});
        exp_q.push_back({5'(9 + sent), 32'h1001 + 32'(sent)});
        sent += 2; acc = 2;
      end else begin
        drive(0, 0, 0, 0, 0, 0);
        acc = 0;
      end
      cnt = cnt + acc - ((cnt > 0) ? 1 : 0);
    end
    if (budget >= 40) begin
      n_checks++; n_fail++;
      $display("FAIL fill timeout: got %0d writes expected 8", writes);
    end
    check("fill write count", 32'(writes), 8);

    // Reset mid-operation with three entries queued and requests present
    @(negedge clk);
    drive(1, 5'h12, 32'h12, 1, 5'h11, 32'h11);
    @(negedge clk);
    drive(1, 5'h14, 32'h14, 1, 5'h13, 32'h13);
    @(negedge clk);
    drive(1, 5'h16, 32'h16, 1, 5'h15, 32'h15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; drive(0, 0, 0, 0, 0, 0);
    rs = 5'h12; rt = 5'h13; #1;
    check("post-reset regwrite", 32'(regwrite), 0);
    check("post-reset rd", 32'(rd), 0);
    check("post-reset writedata", writedata, 0);
    check("post-reset wb_ready", 32'(wb_ready), 1);
    check("post-reset rs_pending", 32'(rs_pending), 0);
    check("post-reset rt_pending", 32'(rt_pending), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      check($sformatf("stale write c%0d", i), 32'(regwrite), 0);
      check($sformatf("stale rs_pending c%0d", i), 32'(rs_pending), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
